bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: MSB-first bit stream with a one-word hold
// register so that a following word can be queued while the current one shifts.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_en,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             hold_valid;
    logic             last_q;

    logic accept;
    logic last_bit;
    logic free;

    // Handshake: a word transfers on a rising edge when din_en=1 and din_ready=1
    // in the preceding cycle; din_ready depends only on the hold register.
    assign accept   = din_en & ~hold_valid;
    assign last_bit = busy & (cnt == '0);
    assign free     = ~busy | last_bit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg      <= '0;
            hold       <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            hold_valid <= 1'b0;
            last_q     <= 1'b0;
        end else if (free) begin
            // Shifter finishes (or is idle): the held word has priority, since
            // an accept is impossible while the hold register is full.
            last_q <= 1'b0;
            if (hold_valid) begin
                shreg      <= hold;
                cnt        <= CW'(WIDTH - 1);
                busy       <= 1'b1;
                hold_valid <= 1'b0;
            end else if (accept) begin
                shreg <= din;
                cnt   <= CW'(WIDTH - 1);
                busy  <= 1'b1;
            end else begin
                shreg <= '0;
                cnt   <= '0;
                busy  <= 1'b0;
            end
        end else begin
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            cnt    <= cnt - CW'(1);
            last_q <= (cnt == CW'(1));
            if (accept) begin
                hold       <= din;
                hold_valid <= 1'b1;
            end
        end
    end

    // shreg is cleared when idle, so its MSB is already 0 outside a word.
    assign din_ready  = ~hold_valid;
    assign dout       = shreg[WIDTH-1];
    assign dout_valid = busy;
    assign dout_last  = last_q;

endmodule
